control_word_sequencer: RTL and testbench
=========================================

CONTROL_WORD_SEQUENCER -- requirements
Module: control_word_sequencer

Interface
REQ-001 Parameter: CW_WIDTH, default 33, control-word width in bits.
REQ-002 Parameter: RESET_STATE, default 2'b00, state value loaded at reset (fetch).
REQ-003 Port: clock  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  reset, synchronous and active-low.
REQ-005 Port: controlword  input  33  control word from the active instruction decoder.
REQ-006 Port: constant_in  input  64  decoder constant; passed to constant_out unchanged.
REQ-007 Port: instruction_in  input  32  instruction word from the memory data bus.
REQ-008 Port: alu_status  input  5  ALU flags {V,C,N,Z,Zraw}; Zraw is the zero flag of the current result.
REQ-009 Port: ram_ready  input  1  RAM has completed the access this cycle.
REQ-010 Port: instruction  output  32  instruction register contents.
REQ-011 Port: state  output  2  current sequencer state.
REQ-012 Port: status  output  5  status register contents.
REQ-013 Port: field outputs, all outputs: alu_en 1, alu_b_sel 1, alu_fs 5, rf_b_en 1, rf_sa 5, rf_sb 5, rf_da 5, rf_write 1, ram_en 1, ram_write 1, pc_en 1, pc_fs 2, pc_in_sel 1; each carries the matching control-word bits after gating.
REQ-014 Port: constant_out  output  64  constant presented to the datapath.
REQ-015 Port: stall  output  1  high while a RAM access waits for ram_ready.

Function
REQ-016 Control-word bit map, MSB first: [32] alu_en, [31] alu_b_sel, [30:26] alu_fs, [25] rf_b_en, [24:20] rf_sa, [19:15] rf_sb, [14:10] rf_da, [9] rf_write, [8] ram_en, [7] ram_write, [6] pc_en, [5:4] pc_fs, [3] pc_in_sel, [2] status_load, [1:0] next_state.
REQ-017 Field outputs are combinational from controlword, with zero-latency gating as defined in REQ-018 to REQ-020.
REQ-018 stall = ram_en AND NOT ram_ready.
REQ-019 While stall is high: rf_write, ram_write and pc_en are forced to 0, and the state, status and instruction registers hold.
REQ-020 Conditional branch:
  - Applies when pc_fs = 2'b11, for the CBZ and CBNZ instructions.
  - taken = Zraw XOR instruction[24].
  - Taken: output pc_fs = 2'b11.
  - Not taken: output pc_fs = 2'b01 (PC increment) and pc_in_sel = 0.
  - pc_fs values 00, 01 and 10 pass through unmodified.
REQ-021 State register: loads controlword[1:0] on each non-stalled edge.
REQ-022 States: 00 fetch, 01 execute-1, 10 execute-2, 11 execute-3.
REQ-023 Illegal or unused state transitions are not checked; the next_state value is trusted.
REQ-024 Instruction register: loads instruction_in on a non-stalled edge when state = 00; holds otherwise.
REQ-025 Status register: loads alu_status on a non-stalled edge when controlword[2] = 1; holds otherwise.
REQ-026 Status and state load together: both update on the same edge, with no priority between them.
REQ-027 A RAM access with ram_ready high in the same cycle completes with no stall cycle.
REQ-028 Reset held mid-stall: the reset values of REQ-029 win over the stall hold.

Reset
REQ-029 While reset = 0 at a clock edge, the following load: state = RESET_STATE, status = 5'b0, instruction = 32'b0.
REQ-030 Field outputs remain combinational during reset.
REQ-031 The first non-reset cycle is a fetch.

Structure
REQ-032 A shared package holds:
  - The CW_WIDTH constant.
  - The bit-position constants of REQ-016.
  - The state encodings of REQ-022.
  - The pc_fs encodings: 00 hold, 01 increment, 10 load, 11 branch.
REQ-033 The branch-condition logic is one sub-module, branch_resolver: inputs pc_fs, pc_in_sel, Zraw and instruction[24]; outputs the resolved pc_fs and pc_in_sel.

Verification
REQ-034 Scenario: hold reset low for 2 cycles, then release -> state = 00, status = 0, instruction = 0; the next edge loads instruction_in = 32'hB4000041.
REQ-035 Scenario: CBZ branch resolution, with instruction[24] = 0 and pc_fs = 11.
  - Zraw = 1 -> pc_fs = 11, pc_in_sel = 1.
  - Zraw = 0 -> pc_fs = 01, pc_in_sel = 0.
REQ-036 Scenario: CBNZ branch resolution, with instruction[24] = 1 and Zraw = 0 -> pc_fs = 11.
REQ-037 Scenario: ram_en = 1, ram_write = 1, ram_ready = 0 for 3 cycles, then 1 -> stall is high for 3 cycles with ram_write = 0 and state held; on the 4th cycle ram_write = 1 and state advances.
REQ-038 Scenario: status_load = 1 with alu_status = 5'b10101 -> status = 10101 after the edge; with status_load = 0 and alu_status = 5'b11111 -> status stays 10101.
REQ-039 Scenario: state = 01, assert reset during a stall -> state = 00 and status = 0 on the next edge.

Source files
------------

// File: rtl/control_word_sequencer_pkg.sv
// Shared definitions for the control word sequencer.
// Holds the control-word width, the control-word bit map, the sequencer
// state encodings and the program-counter function encodings.
package control_word_sequencer_pkg;

  localparam int unsigned CW_WIDTH = 33;

  // Control-word bit map, MSB first
  localparam int unsigned CW_ALU_EN      = 32;
  localparam int unsigned CW_ALU_B_SEL   = 31;
  localparam int unsigned CW_ALU_FS_HI   = 30;
  localparam int unsigned CW_ALU_FS_LO   = 26;
  localparam int unsigned CW_RF_B_EN     = 25;
  localparam int unsigned CW_RF_SA_HI    = 24;
  localparam int unsigned CW_RF_SA_LO    = 20;
  localparam int unsigned CW_RF_SB_HI    = 19;
  localparam int unsigned CW_RF_SB_LO    = 15;
  localparam int unsigned CW_RF_DA_HI    = 14;
  localparam int unsigned CW_RF_DA_LO    = 10;
  localparam int unsigned CW_RF_WRITE    = 9;
  localparam int unsigned CW_RAM_EN      = 8;
  localparam int unsigned CW_RAM_WRITE   = 7;
  localparam int unsigned CW_PC_EN       = 6;
  localparam int unsigned CW_PC_FS_HI    = 5;
  localparam int unsigned CW_PC_FS_LO    = 4;
  localparam int unsigned CW_PC_IN_SEL   = 3;
  localparam int unsigned CW_STATUS_LOAD = 2;
  localparam int unsigned CW_NEXT_HI     = 1;
  localparam int unsigned CW_NEXT_LO     = 0;

  // Zraw position in alu_status and the CBZ/CBNZ discriminator in the instruction
  localparam int unsigned STATUS_ZRAW    = 0;
  localparam int unsigned INSTR_NZ_BIT   = 24;

  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_EXEC1 = 2'b01,
    ST_EXEC2 = 2'b10,
    ST_EXEC3 = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    PC_HOLD   = 2'b00,
    PC_INC    = 2'b01,
    PC_LOAD   = 2'b10,
    PC_BRANCH = 2'b11
  } pc_fs_e;

endpackage

// File: rtl/control_word_sequencer_branch_resolver.sv
// branch_resolver: resolves CBZ/CBNZ conditional branches.
// Ports:
//   pc_fs_i      - pc_fs field from the control word
//   pc_in_sel_i  - pc_in_sel field from the control word
//   zraw_i       - zero flag of the current ALU result
//   instr_nz_i   - instruction bit 24 (0 = CBZ, 1 = CBNZ)
//   pc_fs_o      - resolved pc_fs
//   pc_in_sel_o  - resolved pc_in_sel
module branch_resolver
  import control_word_sequencer_pkg::*;
(
  input  logic [1:0] pc_fs_i,
  input  logic       pc_in_sel_i,
  input  logic       zraw_i,
  input  logic       instr_nz_i,
  output logic [1:0] pc_fs_o,
  output logic       pc_in_sel_o
);

  logic taken;

  always_comb begin
    pc_fs_o     = pc_fs_i;
    pc_in_sel_o = pc_in_sel_i;
    // CBZ branches on zero, CBNZ on non-zero: XOR with the opcode bit covers both
    taken       = zraw_i ^ instr_nz_i;
    if ((pc_fs_e'(pc_fs_i) == PC_BRANCH) && !taken) begin
      pc_fs_o     = PC_INC;
      pc_in_sel_o = 1'b0;
    end
  end

endmodule

// File: rtl/control_word_sequencer.sv
// control_word_sequencer: decodes the active control word into datapath
// controls, resolves conditional branches, stalls on pending RAM accesses
// and holds the state, status and instruction registers.
// Ports:
//   clock, reset      - rising-edge clock, synchronous active-low reset
//   controlword       - control word from the active decoder
//   constant_in/out   - decoder constant, passed through
//   instruction_in    - instruction word from the memory data bus
//   alu_status        - ALU flags {V,C,N,Z,Zraw}
//   ram_ready         - RAM access completes this cycle
//   instruction       - instruction register
//   state             - sequencer state
//   status            - status register
//   alu_*, rf_*, ram_*, pc_* - gated control-word fields
//   stall             - RAM access waiting for ram_ready
module control_word_sequencer #(
  parameter int unsigned CW_WIDTH    = control_word_sequencer_pkg::CW_WIDTH,
  parameter logic [1:0]  RESET_STATE = 2'b00
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CW_WIDTH-1:0] controlword,
  input  logic [63:0]         constant_in,
  input  logic [31:0]         instruction_in,
  input  logic [4:0]          alu_status,
  input  logic                ram_ready,
  output logic [31:0]         instruction,
  output logic [1:0]          state,
  output logic [4:0]          status,
  output logic                alu_en,
  output logic                alu_b_sel,
  output logic [4:0]          alu_fs,
  output logic                rf_b_en,
  output logic [4:0]          rf_sa,
  output logic [4:0]          rf_sb,
  output logic [4:0]          rf_da,
  output logic                rf_write,
  output logic                ram_en,
  output logic                ram_write,
  output logic                pc_en,
  output logic [1:0]          pc_fs,
  output logic                pc_in_sel,
  output logic [63:0]         constant_out,
  output logic                stall
);

  import control_word_sequencer_pkg::*;

  state_e      state_q, state_d;
  logic [4:0]  status_q, status_d;
  logic [31:0] instr_q, instr_d;
  logic        stall_w;

  assign stall_w = controlword[CW_RAM_EN] & ~ram_ready;

  // State register (also carries status and instruction registers)
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= state_e'(RESET_STATE);
      status_q <= '0;
      instr_q  <= '0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      instr_q  <= instr_d;
    end
  end

  // Next-state logic: everything holds while stalled
  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    instr_d  = instr_q;
    if (!stall_w) begin
      state_d = state_e'(controlword[CW_NEXT_HI:CW_NEXT_LO]);
      if (controlword[CW_STATUS_LOAD]) status_d = alu_status;
      if (state_q == ST_FETCH)         instr_d  = instruction_in;
    end
  end

  logic [1:0] pc_fs_res;
  logic       pc_in_sel_res;

  branch_resolver u_branch_resolver (
    .pc_fs_i     (controlword[CW_PC_FS_HI:CW_PC_FS_LO]),
    .pc_in_sel_i (controlword[CW_PC_IN_SEL]),
    .zraw_i      (alu_status[STATUS_ZRAW]),
    .instr_nz_i  (instr_q[INSTR_NZ_BIT]),
    .pc_fs_o     (pc_fs_res),
    .pc_in_sel_o (pc_in_sel_res)
  );

  // Output logic: fields are combinational from the control word
  always_comb begin
    alu_en       = controlword[CW_ALU_EN];
    alu_b_sel    = controlword[CW_ALU_B_SEL];
    alu_fs       = controlword[CW_ALU_FS_HI:CW_ALU_FS_LO];
    rf_b_en      = controlword[CW_RF_B_EN];
    rf_sa        = controlword[CW_RF_SA_HI:CW_RF_SA_LO];
    rf_sb        = controlword[CW_RF_SB_HI:CW_RF_SB_LO];
    rf_da        = controlword[CW_RF_DA_HI:CW_RF_DA_LO];
    rf_write     = controlword[CW_RF_WRITE] & ~stall_w;
    ram_en       = controlword[CW_RAM_EN];
    ram_write    = controlword[CW_RAM_WRITE] & ~stall_w;
    pc_en        = controlword[CW_PC_EN] & ~stall_w;
    pc_fs        = pc_fs_res;
    pc_in_sel    = pc_in_sel_res;
    constant_out = constant_in;
    stall        = stall_w;
    instruction  = instr_q;
    state        = state_q;
    status       = status_q;
  end

endmodule

// File: tb/tb_control_word_sequencer.sv
module tb_control_word_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic [32:0] controlword;
  logic [63:0] constant_in;
  logic [31:0] instruction_in;
  logic [4:0]  alu_status;
  logic        ram_ready;
  logic [31:0] instruction;
  logic [1:0]  state;
  logic [4:0]  status;
  logic        alu_en, alu_b_sel, rf_b_en, rf_write, ram_en, ram_write, pc_en, pc_in_sel, stall;
  logic [4:0]  alu_fs, rf_sa, rf_sb, rf_da;
  logic [1:0]  pc_fs;
  logic [63:0] constant_out;

  int checks = 0;
  int errors = 0;

  control_word_sequencer #(.CW_WIDTH(33), .RESET_STATE(2'b00)) dut (
    .clock(clock), .reset(reset), .controlword(controlword), .constant_in(constant_in),
    .instruction_in(instruction_in), .alu_status(alu_status), .ram_ready(ram_ready),
    .instruction(instruction), .state(state), .status(status),
    .alu_en(alu_en), .alu_b_sel(alu_b_sel), .alu_fs(alu_fs), .rf_b_en(rf_b_en),
    .rf_sa(rf_sa), .rf_sb(rf_sb), .rf_da(rf_da), .rf_write(rf_write),
    .ram_en(ram_en), .ram_write(ram_write), .pc_en(pc_en), .pc_fs(pc_fs),
    .pc_in_sel(pc_in_sel), .constant_out(constant_out), .stall(stall)
  );

  always #5 clock = ~clock;

  // Builds a control word from its fields, MSB first
  function automatic logic [32:0] mk_cw(
    input logic ae, input logic bs, input logic [4:0] fs, input logic rbe,
    input logic [4:0] sa, input logic [4:0] sb, input logic [4:0] da, input logic rw,
    input logic re, input logic mw, input logic pe, input logic [1:0] pf,
    input logic ps, input logic sl, input logic [1:0] ns);
    return {ae, bs, fs, rbe, sa, sb, da, rw, re, mw, pe, pf, ps, sl, ns};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; ram_ready = 1'b0; alu_status = 5'b11111;
    constant_in = 64'h0; instruction_in = 32'hB4000041;
    controlword = mk_cw(0,0,5'b10110,0,0,0,0,0,0,0,0,2'b00,0,1,2'b01);
    tick(); tick();
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL reset_state got %h exp 0", state); end
    checks++; if (status !== 5'b0) begin errors++; $display("FAIL reset_status got %h exp 0", status); end
    checks++; if (instruction !== 32'h0) begin errors++; $display("FAIL reset_instr got %h exp 0", instruction); end
    checks++; if (alu_fs !== 5'b10110) begin errors++; $display("FAIL reset_comb_alu_fs got %b exp 10110", alu_fs); end
    reset = 1'b1;
    controlword = mk_cw(0,0,5'b10110,0,0,0,0,0,0,0,0,2'b00,0,0,2'b01);
    tick();
    checks++; if (instruction !== 32'hB4000041) begin errors++; $display("FAIL first_fetch got %h exp B4000041", instruction); end
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL first_state got %h exp 1", state); end
    checks++; if (status !== 5'b0) begin errors++; $display("FAIL first_status got %h exp 0", status); end
  endtask

  task automatic test_fields();
    controlword = 33'h1_2345_6789; ram_ready = 1'b1; alu_status = 5'b0;
    constant_in = 64'hDEAD_BEEF_0123_4567;
    #1;
    checks++; if ({alu_en, alu_b_sel, alu_fs, rf_b_en} !== 8'b1_0_01000_1) begin errors++; $display("FAIL raw_alu got %b exp 10010001", {alu_en, alu_b_sel, alu_fs, rf_b_en}); end
    checks++; if ({rf_sa, rf_sb, rf_da} !== 15'b10100_01010_11001) begin errors++; $display("FAIL raw_rf got %b exp 101000101011001", {rf_sa, rf_sb, rf_da}); end
    checks++; if ({rf_write, ram_en, ram_write, pc_en, pc_fs, pc_in_sel, stall} !== 8'b1_1_1_0_00_1_0) begin errors++; $display("FAIL raw_ctl got %b exp 11100010", {rf_write, ram_en, ram_write, pc_en, pc_fs, pc_in_sel, stall}); end
    checks++; if (constant_out !== 64'hDEAD_BEEF_0123_4567) begin errors++; $display("FAIL const1 got %h exp DEADBEEF01234567", constant_out); end
    controlword = mk_cw(0,1,5'b10011,0,5'b00001,5'b11110,5'b10000,0,0,1,1,2'b10,0,0,2'b01);
    constant_in = 64'h0F0F_0000_FFFF_1234;
    #1;
    checks++; if ({alu_en, alu_b_sel, alu_fs, rf_b_en} !== 8'b0_1_10011_0) begin errors++; $display("FAIL mk_alu got %b exp 01100110", {alu_en, alu_b_sel, alu_fs, rf_b_en}); end
    checks++; if ({rf_sa, rf_sb, rf_da} !== 15'b00001_11110_10000) begin errors++; $display("FAIL mk_rf got %b exp 000011111010000", {rf_sa, rf_sb, rf_da}); end
    checks++; if ({rf_write, ram_en, ram_write, pc_en, pc_fs, pc_in_sel, stall} !== 8'b0_0_1_1_10_0_0) begin errors++; $display("FAIL mk_ctl got %b exp 00111000", {rf_write, ram_en, ram_write, pc_en, pc_fs, pc_in_sel, stall}); end
    checks++; if (constant_out !== 64'h0F0F_0000_FFFF_1234) begin errors++; $display("FAIL const2 got %h exp 0F0F0000FFFF1234", constant_out); end
  endtask

  task automatic test_cbz();
    // instruction register holds B4000041: bit 24 = 0 (CBZ)
    controlword = mk_cw(0,0,0,0,0,0,0,0,0,0,1,2'b11,1,0,2'b01);
    alu_status = 5'b00001;
    #1;
    checks++; if ({pc_fs, pc_in_sel} !== 3'b11_1) begin errors++; $display("FAIL cbz_taken got %b exp 111", {pc_fs, pc_in_sel}); end
    alu_status = 5'b00000;
    #1;
    checks++; if ({pc_fs, pc_in_sel} !== 3'b01_0) begin errors++; $display("FAIL cbz_not_taken got %b exp 010", {pc_fs, pc_in_sel}); end
    controlword = mk_cw(0,0,0,0,0,0,0,0,0,0,1,2'b10,1,0,2'b01);
    #1;
    checks++; if ({pc_fs, pc_in_sel} !== 3'b10_1) begin errors++; $display("FAIL pass_load got %b exp 101", {pc_fs, pc_in_sel}); end
    controlword = mk_cw(0,0,0,0,0,0,0,0,0,0,1,2'b00,1,0,2'b01);
    #1;
    checks++; if ({pc_fs, pc_in_sel} !== 3'b00_1) begin errors++; $display("FAIL pass_hold got %b exp 001", {pc_fs, pc_in_sel}); end
  endtask

  task automatic test_cbnz();
    controlword = mk_cw(0,0,0,0,0,0,0,0,0,0,0,2'b00,0,0,2'b00);
    tick();
    instruction_in = 32'hB5000041;
    controlword = mk_cw(0,0,0,0,0,0,0,0,0,0,0,2'b00,0,0,2'b01);
    tick();
    checks++; if (instruction !== 32'hB5000041) begin errors++; $display("FAIL cbnz_fetch got %h exp B5000041", instruction); end
    controlword = mk_cw(0,0,0,0,0,0,0,0,0,0,1,2'b11,1,0,2'b01);
    alu_status = 5'b00000;
    #1;
    checks++; if ({pc_fs, pc_in_sel} !== 3'b11_1) begin errors++; $display("FAIL cbnz_taken got %b exp 111", {pc_fs, pc_in_sel}); end
    alu_status = 5'b00001;
    #1;
    checks++; if ({pc_fs, pc_in_sel} !== 3'b01_0) begin errors++; $display("FAIL cbnz_not_taken got %b exp 010", {pc_fs, pc_in_sel}); end
  endtask

  task automatic test_stall();
    controlword = mk_cw(0,0,0,0,0,0,0,0,0,0,0,2'b00,0,0,2'b00);
    tick();
    instruction_in = 32'h1234_5678; alu_status = 5'b01110; ram_ready = 1'b0;
    controlword = mk_cw(0,0,0,0,0,0,0,1,1,1,1,2'b01,0,1,2'b10);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if ({stall, ram_write, rf_write, pc_en} !== 4'b1000) begin errors++; $display("FAIL stall_gate%0d got %b exp 1000", c, {stall, ram_write, rf_write, pc_en}); end
      tick();
      checks++; if ({state, status, instruction} !== {2'b00, 5'b0, 32'hB5000041}) begin errors++; $display("FAIL stall_hold%0d got %h/%h/%h exp 0/0/B5000041", c, state, status, instruction); end
    end
    ram_ready = 1'b1;
    #1;
    checks++; if ({stall, ram_write, rf_write, pc_en} !== 4'b0111) begin errors++; $display("FAIL ready_gate got %b exp 0111", {stall, ram_write, rf_write, pc_en}); end
    tick();
    checks++; if ({state, status, instruction} !== {2'b10, 5'b01110, 32'h1234_5678}) begin errors++; $display("FAIL ready_adv got %h/%h/%h exp 2/0e/12345678", state, status, instruction); end
  endtask

  task automatic test_status();
    ram_ready = 1'b0;
    alu_status = 5'b10101;
    controlword = mk_cw(0,0,0,0,0,0,0,0,0,0,0,2'b00,0,1,2'b11);
    tick();
    checks++; if ({status, state} !== {5'b10101, 2'b11}) begin errors++; $display("FAIL status_load got %b exp 1010111", {status, state}); end
    alu_status = 5'b11111;
    controlword = mk_cw(0,0,0,0,0,0,0,0,0,0,0,2'b00,0,0,2'b01);
    tick();
    checks++; if ({status, state} !== {5'b10101, 2'b01}) begin errors++; $display("FAIL status_hold got %b exp 1010101", {status, state}); end
  endtask

  task automatic test_reset_mid_stall();
    ram_ready = 1'b0; alu_status = 5'b00011;
    controlword = mk_cw(0,0,0,0,0,0,0,0,1,1,0,2'b00,0,1,2'b10);
    tick();
    checks++; if ({stall, state, status} !== {1'b1, 2'b01, 5'b10101}) begin errors++; $display("FAIL pre_reset_stall got %b exp 10110101", {stall, state, status}); end
    reset = 1'b0;
    tick();
    checks++; if ({state, status, instruction} !== {2'b00, 5'b0, 32'h0}) begin errors++; $display("FAIL reset_in_stall got %h/%h/%h exp 0/0/0", state, status, instruction); end
    reset = 1'b1; instruction_in = 32'hCAFE_0001;
    controlword = mk_cw(0,0,0,0,0,0,0,0,0,0,0,2'b00,0,0,2'b01);
    tick();
    checks++; if ({state, instruction} !== {2'b01, 32'hCAFE_0001}) begin errors++; $display("FAIL post_reset_fetch got %h/%h exp 1/CAFE0001", state, instruction); end
  endtask

  initial begin
    test_reset();
    test_fields();
    test_cbz();
    test_cbnz();
    test_stall();
    test_status();
    test_reset_mid_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
